// File: rtl/nrz_to_pam4.sv
// Serial NRZ to PAM4 transmit converter: pairs consecutive qualified bits into
// 2-bit level codes, with optional Gray mapping, realignment and a symbol counter.
module nrz_to_pam4 #(
    parameter bit          GRAY      = 1'b1,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             nrz_in,
    input  logic             nrz_valid,
    input  logic             align,
    output logic [1:0]       pam4_out,
    output logic             pam4_valid,
    output logic             pair_err,
    output logic [CNT_W-1:0] sym_count
);

    localparam int unsigned SYM_W = 2;

    typedef enum logic {
        S_FIRST  = 1'b0,
        S_SECOND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               held_q, held_d;
    logic [SYM_W-1:0]   pam4_q, pam4_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [SYM_W-1:0]   pair_c;
    logic [SYM_W-1:0]   level_c;

    // Pair ordering and level mapping for the bit completing the current pair
    always_comb begin
        pair_c  = MSB_FIRST ? {held_q, nrz_in} : {nrz_in, held_q};
        level_c = GRAY ? {pair_c[1], pair_c[1] ^ pair_c[0]} : pair_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FIRST;
            held_q  <= 1'b0;
            pam4_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            pam4_q  <= pam4_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; align overrides pairing and restarts the pair on this cycle's bit
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        pam4_d  = pam4_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;

        if (align) begin
            err_d  = (state_q == S_SECOND);
            held_d = 1'b0;
            if (nrz_valid) begin
                held_d  = nrz_in;
                state_d = S_SECOND;
            end else begin
                state_d = S_FIRST;
            end
        end else begin
            case (state_q)
                S_FIRST: begin
                    if (nrz_valid) begin
                        held_d  = nrz_in;
                        state_d = S_SECOND;
                    end
                end
                S_SECOND: begin
                    if (nrz_valid) begin
                        pam4_d  = level_c;
                        valid_d = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                        held_d  = 1'b0;
                        state_d = S_FIRST;
                    end
                end
                default: state_d = S_FIRST;
            endcase
        end
    end

    assign pam4_out   = pam4_q;
    assign pam4_valid = valid_q;
    assign pair_err   = err_q;
    assign sym_count  = cnt_q;

endmodule

// File: tb/tb_nrz_to_pam4.sv
// Bench for nrz_to_pam4: four parameter variants share one input stream and are
// checked every cycle against a pair-collecting reference model.
module tb_nrz_to_pam4;

    logic clk = 1'b0;
    logic reset;
    logic nrz_in, nrz_valid, align;

    logic [1:0] po [4];
    logic       pv [4];
    logic       pe [4];
    logic [7:0] sc0, sc1, sc2;
    logic [1:0] sc3;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state per variant
    int m_held [4];
    int m_hb   [4];
    int m_out  [4];
    int m_vld  [4];
    int m_err  [4];
    int m_cnt  [4];

    always #5 clk = ~clk;

    nrz_to_pam4 #(.GRAY(1'b1), .MSB_FIRST(1'b1), .CNT_W(8)) u_g_msb (
        .clk(clk), .reset(reset), .nrz_in(nrz_in), .nrz_valid(nrz_valid), .align(align),
        .pam4_out(po[0]), .pam4_valid(pv[0]), .pair_err(pe[0]), .sym_count(sc0));
    nrz_to_pam4 #(.GRAY(1'b0), .MSB_FIRST(1'b0), .CNT_W(8)) u_b_lsb (
        .clk(clk), .reset(reset), .nrz_in(nrz_in), .nrz_valid(nrz_valid), .align(align),
        .pam4_out(po[1]), .pam4_valid(pv[1]), .pair_err(pe[1]), .sym_count(sc1));
    nrz_to_pam4 #(.GRAY(1'b0), .MSB_FIRST(1'b1), .CNT_W(8)) u_b_msb (
        .clk(clk), .reset(reset), .nrz_in(nrz_in), .nrz_valid(nrz_valid), .align(align),
        .pam4_out(po[2]), .pam4_valid(pv[2]), .pair_err(pe[2]), .sym_count(sc2));
    nrz_to_pam4 #(.GRAY(1'b1), .MSB_FIRST(1'b1), .CNT_W(2)) u_g_w2 (
        .clk(clk), .reset(reset), .nrz_in(nrz_in), .nrz_valid(nrz_valid), .align(align),
        .pam4_out(po[3]), .pam4_valid(pv[3]), .pair_err(pe[3]), .sym_count(sc3));

    function automatic int cfg_gray(int i);
        return (i == 0 || i == 3) ? 1 : 0;
    endfunction

    function automatic int cfg_msb(int i);
        return (i == 1) ? 0 : 1;
    endfunction

    function automatic int cfg_cw(int i);
        return (i == 3) ? 2 : 8;
    endfunction

    // level from the pair value: binary value, Gray encoded as v ^ (v >> 1)
    function automatic int level(int i, int first, int second);
        int v;
        v = (cfg_msb(i) != 0) ? (2 * first + second) : (2 * second + first);
        return (cfg_gray(i) != 0) ? (v ^ (v >> 1)) : v;
    endfunction

    function automatic logic [31:0] obs_cnt(int i);
        case (i)
            0:       return 32'(sc0);
            1:       return 32'(sc1);
            2:       return 32'(sc2);
            default: return 32'(sc3);
        endcase
    endfunction

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, i, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_held[i] = 0; m_hb[i] = 0; m_out[i] = 0;
            m_vld[i]  = 0; m_err[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic model_edge(input int v, input int b, input int a);
        for (int i = 0; i < 4; i++) begin
            m_vld[i] = 0;
            m_err[i] = 0;
            if (a != 0) begin
                m_err[i]  = m_held[i];
                m_held[i] = v;
                m_hb[i]   = b;
            end else if (v != 0) begin
                if (m_held[i] == 0) begin
                    m_held[i] = 1;
                    m_hb[i]   = b;
                end else begin
                    m_out[i]  = level(i, m_hb[i], b);
                    m_vld[i]  = 1;
                    m_cnt[i]  = (m_cnt[i] + 1) % (1 << cfg_cw(i));
                    m_held[i] = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            chk("pam4_out",   i, 32'(po[i]), 32'(m_out[i]));
            chk("pam4_valid", i, 32'(pv[i]), 32'(m_vld[i]));
            chk("pair_err",   i, 32'(pe[i]), 32'(m_err[i]));
            chk("sym_count",  i, obs_cnt(i), 32'(m_cnt[i]));
        end
    endtask

    // drive one cycle of inputs, let the edge happen, then check all variants
    task automatic step(input int v, input int b, input int a);
        nrz_valid = v[0];
        nrz_in    = b[0];
        align     = a[0];
        @(posedge clk);
        model_edge(v, b, a);
        #1;
        check_all();
    endtask

    // asynchronous reset asserted mid-cycle, checked before any clock edge
    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        #2 reset = 1'b0;
    endtask

    initial begin
        int exp1 [4];
        int bits1 [8];
        int wrap_exp [5];
        logic [31:0] c0;

        exp1     = '{0, 1, 2, 3};
        bits1    = '{0, 0, 0, 1, 1, 1, 1, 0};
        wrap_exp = '{1, 2, 3, 0, 1};

        reset = 1'b1; nrz_in = 1'b0; nrz_valid = 1'b0; align = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Gray, MSB first, continuous valid
        for (int k = 0; k < 8; k++) begin
            step(1, bits1[k], 0);
            if (k % 2 == 1) begin
                chk("t1_pam4", 0, 32'(po[0]), 32'(exp1[k / 2]));
                chk("t1_strobe", 0, 32'(pv[0]), 32'd1);
            end else begin
                chk("t1_nostrobe", 0, 32'(pv[0]), 32'd0);
            end
        end
        chk("t1_count", 0, 32'(sc0), 32'd4);

        // binary LSB first: 1,0 -> 01 then 0,1 -> 10
        step(1, 1, 0); step(1, 0, 0);
        chk("t2_pam4_a", 1, 32'(po[1]), 32'd1);
        step(1, 0, 0); step(1, 1, 0);
        chk("t2_pam4_b", 1, 32'(po[1]), 32'd2);

        // gapped valid, held bit survives the gap
        step(1, 1, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, k % 2, 0);
            chk("t3_gap", 0, 32'(pv[0]), 32'd0);
        end
        step(1, 1, 0);
        chk("t3_strobe", 0, 32'(pv[0]), 32'd1);
        chk("t3_pam4", 0, 32'(po[0]), 32'd2);
        step(0, 0, 0);
        chk("t3_one_cycle", 0, 32'(pv[0]), 32'd0);

        // realign with a bit on the align cycle
        c0 = 32'(sc0);
        step(1, 1, 0);
        step(1, 0, 1);
        chk("t4_err", 0, 32'(pe[0]), 32'd1);
        chk("t4_noval", 0, 32'(pv[0]), 32'd0);
        step(1, 1, 0);
        chk("t4_err_once", 0, 32'(pe[0]), 32'd0);
        chk("t4_pam4", 0, 32'(po[0]), 32'd1);
        chk("t4_count", 0, 32'(sc0), c0 + 32'd1);

        // align in S_FIRST is silent
        step(0, 0, 1);
        chk("t4_align_idle", 0, 32'(pe[0]), 32'd0);

        // counter wrap on the 2-bit variant, then reset with a bit held
        async_reset();
        for (int k = 0; k < 5; k++) begin
            step(1, k % 2, 0);
            step(1, 1, 0);
            chk("t5_wrap", 3, 32'(sc3), 32'(wrap_exp[k]));
        end
        step(1, 1, 0);
        async_reset();
        chk("t5_rst_out", 0, 32'(po[0]), 32'd0);
        chk("t5_rst_err", 0, 32'(pe[0]), 32'd0);
        step(0, 0, 0);
        chk("t5_no_err", 0, 32'(pe[0]), 32'd0);
        step(1, 1, 0); step(1, 0, 0);
        chk("t5_post_pam4", 0, 32'(po[0]), 32'd3);
        chk("t5_post_cnt", 3, 32'(sc3), 32'd1);

        // randomized traffic with occasional align and reset
        for (int k = 0; k < 400; k++) begin
            if (($urandom % 97) == 0) async_reset();
            step(int'(($urandom % 4) != 0), int'($urandom % 2), int'(($urandom % 12) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nrz_to_pam4.md
Name: nrz_to_pam4

Overview:
Serial NRZ-to-PAM4 transmit-side converter.
- Accepts one NRZ bit per qualified clock and pairs consecutive bits into one 2-bit PAM4 level code.
- Optionally Gray-maps each pair before presenting it.
- Sits ahead of the PAM4 line driver and is the counterpart of the PAM4-to-NRZ receive converter.
- Provides symbol-boundary alignment, a broken-pair flag and a symbol counter for link bring-up.

Parameters:
GRAY, 1, 1 = Gray-map each pair to a level code; 0 = pass the pair through as a binary code.
MSB_FIRST, 1, 1 = first received bit is the pair MSB; 0 = first received bit is the pair LSB.
CNT_W, 8, width of the symbol counter.

Ports:
clk  input  1  clock; all logic is rising-edge.
reset  input  1  asynchronous, active-high reset.
nrz_in  input  1  serial NRZ data bit.
nrz_valid  input  1  nrz_in is qualified this cycle.
align  input  1  synchronous pulse marking the start of a new pair.
pam4_out  output  2  PAM4 level code, 00 = lowest level, 11 = highest level.
pam4_valid  output  1  one-cycle strobe: pam4_out was updated this cycle.
pair_err  output  1  one-cycle strobe: a half-built pair was discarded.
sym_count  output  CNT_W  count of emitted symbols; wraps.

Behaviour:
- Reset (asynchronous, active-high) forces all of the following immediately, with no clock needed:
  - state = S_FIRST, held bit = 0;
  - pam4_out = 00, pam4_valid = 0, pair_err = 0, sym_count = 0.
- Reset asserted mid-pair discards the held bit silently; pair_err is not raised.
- State machine has two states:
  - S_FIRST: no bit held.
  - S_SECOND: one bit held.
- S_FIRST with nrz_valid = 1: capture nrz_in as the held bit; go to S_SECOND.
- S_FIRST with nrz_valid = 0: hold state.
- S_SECOND with nrz_valid = 0: hold state; the held bit is kept indefinitely with no timeout.
- S_SECOND with nrz_valid = 1:
  - Form pair {b1,b0} = {held, nrz_in} when MSB_FIRST = 1, or {nrz_in, held} when MSB_FIRST = 0.
  - Register the level code into pam4_out; pulse pam4_valid; increment sym_count; go to S_FIRST.
- Level mapping:
  - GRAY = 1: pam4_out = {b1, b1^b0}, giving 00→00, 01→01, 11→10, 10→11.
  - GRAY = 0: pam4_out = {b1, b0}.
- Latency: pam4_out and pam4_valid are registered. They become valid on the clock edge that samples the second bit, and are visible for the cycle after that edge.
- pam4_out holds its last value between strobes; it never returns to 00 except on reset.
- pam4_valid is high for exactly 1 cycle per symbol. Maximum symbol rate is one symbol every 2 clocks.
- sym_count increments by 1 per emitted symbol, modulo 2^CNT_W. Terminal value 2^CNT_W−1 wraps to 0 with no flag.
- align = 1 takes priority over normal pairing:
  - If the state was S_SECOND, the held bit is discarded and pair_err pulses for 1 cycle. No symbol is emitted and sym_count is unchanged.
  - If the state was S_FIRST, align is a no-op apart from its effect on the same-cycle bit described next; pair_err is not raised.
  - align with nrz_valid = 1 in the same cycle: nrz_in is captured as the first bit of the new pair; next state is S_SECOND.
  - align with nrz_valid = 0: next state is S_FIRST.
- align never produces pam4_valid in the cycle it is asserted.
- pam4_valid and pair_err are never high in the same cycle.
- Inputs are synchronous to clk; no internal synchronisers.

Test Plan:
1. Gray pairs: GRAY=1, MSB_FIRST=1; stream bits 0,0,0,1,1,1,1,0 with nrz_valid held high → pam4_out = 00, 01, 10, 11 on four strobes, one strobe every 2 cycles; sym_count = 4.
2. Binary, LSB-first: GRAY=0, MSB_FIRST=0; bits 1,0 → pam4_out = 01; then bits 0,1 → pam4_out = 10.
3. Gapped valid: bit 1, then nrz_valid = 0 for 5 cycles, then bit 1 → a single pam4_valid 1 cycle after the second bit with pam4_out = 10 (GRAY=1); no strobe during the gap.
4. Realign: send bit 1, then align=1 with nrz_valid=1 and nrz_in=0, then bit 1 → pair_err pulses once; the next symbol is pair {0,1}, giving pam4_out = 01; sym_count rises by exactly 1.
5. Wrap and reset: CNT_W=2; emit 5 symbols → sym_count sequence 1, 2, 3, 0, 1. Assert reset asynchronously with one bit held → all outputs 0 immediately and no pair_err; the first post-reset pair decodes correctly.
